ram2vga: RTL and testbench
==========================

# ram2vga

Display-side reader for the 100x100 camera display buffer. Generates 640x480 VGA timing from `sysclk` and reads 3-bit pixels from the display RAM's read port. It shows the image 2x-scaled as a 200x200 window on a black background. It is the consumer of the buffer the camera capture block fills; both share the same 16-bit linear address map (addr = row*100 + col, 0..9999).

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch, sync, back porch (clocks)
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch, sync, back porch (lines)
- WIN_X / WIN_Y, 220 / 140, top-left screen position of the scaled window
- WIN_W / WIN_H, 100 / 100, source image size (on-screen size is 2x each)

Ports:
- sysclk  in  1  pixel clock (24 MHz board clock)
- resetn  in  1  asynchronous, active-low reset
- rdaddr  out  16  display RAM read address
- q  in  3  RAM read data, valid the cycle after `rdaddr` is registered (synchronous RAM, 1-clock latency)
- hs  out  1  horizontal sync, active low
- vs  out  1  vertical sync, active low
- de  out  1  data enable, high in the visible area
- vga_r / vga_g / vga_b  out  3 each  pixel colour (grey: all three equal `q` inside the window, 0 elsewhere)
- frame_tick  out  1  one-cycle pulse per frame

## Operation
- Counters: `h_cnt` runs 0..H_TOTAL-1, with H_TOTAL = sum of H_* = 800. `v_cnt` runs 0..V_TOTAL-1, with V_TOTAL = 525.
  - `v_cnt` increments when `h_cnt` wraps.
  - Both counters wrap to 0 together at (799, 524).
- Raw timing:
  - visible = h_cnt < 640 && v_cnt < 480
  - hs_raw low for h_cnt in [656, 751]
  - vs_raw low for v_cnt in [490, 491]
- Window hit: in_win = h_cnt in [WIN_X, WIN_X+199] && v_cnt in [WIN_Y, WIN_Y+199].
- Address generation is incremental; no multiplier.
  - `col` (7 bit) and `row_base` (14 bit) are held in registers.
  - The phase bits `hphase` and `vphase` select pixel and line duplication.
  - Inside the window, `col` advances every second pixel (when hphase=1). It returns to 0 at the end of each window line.
  - At the end of each window line with vphase=1, `row_base` += WIN_W.
  - Outside the window on lines past the window, `row_base`, `col` and both phases hold. They are cleared to 0 at v_cnt==0, h_cnt==0.
  - Sequence on each window line: 0,0,1,1,…,99,99 plus row_base. Each source row appears on two consecutive screen lines. Last address fetched is 9999.
- `rdaddr` is registered as row_base+col when in_win, and holds its last value otherwise.
- Pipeline (3 stages, every cycle, no stall):
  - S1: `rdaddr`, plus in_win/visible/hs/vs delayed.
  - S2: RAM presents `q`.
  - S3: output registers. These capture `q` (or 0 if not in_win) into vga_r/g/b, plus aligned `de`/`hs`/`vs`.
- `frame_tick` pulses once, aligned with the first `vs` low cycle at the outputs.

## Timing
- Reset values:
  - `rdaddr`=0, `hs`=1, `vs`=1, `de`=0, `vga_r/g/b`=0, `frame_tick`=0
  - all counters, `col`, `row_base` and phases = 0
- After reset release, counting starts at the first rising edge. Reset asserted mid-frame returns all state to the reset values immediately (async). The frame restarts from (0,0) on release; there is no partial-frame recovery.
- Latency: outputs at edge t+3 reflect the counter value sampled at edge t. hs, vs, de and rgb share this latency exactly, so the sync-to-pixel relationship is unchanged.
- Line = 800 clocks, frame = 420000 clocks (~57 Hz at 24 MHz; accepted).
- `rgb` is forced to 0 whenever `de`=0, including inside the window region during blanking. The window parameters are required to lie fully within the visible area.
- The RAM write side (camera) is asynchronous to this reader. Tearing is accepted; no handshake.

## Test plan
- Reset: hold resetn=0 for 10 clocks, then release. Required: hs=vs=1, de=0, rgb=0, rdaddr=0 during reset. The first hs falling edge occurs 656+3 clocks after release.
- Line/frame timing: run 2 frames. Required:
  - hs low for exactly 96 clocks per 800-clock line
  - vs low for exactly 1600 clocks per 420000-clock frame
  - de high 640 clocks/line on 480 lines
  - frame_tick once per frame
- Address sequence: log `rdaddr` while in_win. Required:
  - screen lines 140 and 141 both show 0,0,1,1,…,99,99
  - line 142 starts at 100
  - line 339 ends at 9999
  - no address above 9999
- Data path: RAM model returns q = addr[2:0] with 1-clock latency. Required:
  - at output pixel (WIN_X+2, WIN_Y), rgb = 1
  - at (WIN_X+199, WIN_Y+199), rgb = 9999 mod 8 = 7
  - at (WIN_X-1, WIN_Y) and (WIN_X+200, WIN_Y), rgb = 0
- Mid-frame reset: assert resetn=0 at v_cnt=300 for 3 clocks. Required: outputs go to reset values at once. After release, the next window line starts at rdaddr 0, and the next frame_tick comes 490*800+3 clocks after release.

Source files
------------

// File: rtl/ram2vga.sv
// rtl/ram2vga.sv - VGA timing generator and 2x-scaled reader for the 100x100 display buffer
// Incremental address generation feeding a 3-stage pipeline: address, RAM read, output register.
module ram2vga #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int WIN_X    = 220,
   parameter int WIN_Y    = 140,
   parameter int WIN_W    = 100,
   parameter int WIN_H    = 100
) (
   input  logic        sysclk,
   input  logic        resetn,
   output logic [15:0] rdaddr,
   input  logic [2:0]  q,
   output logic        hs,
   output logic        vs,
   output logic        de,
   output logic [2:0]  vga_r,
   output logic [2:0]  vga_g,
   output logic [2:0]  vga_b,
   output logic        frame_tick
);

   localparam logic [9:0]  H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0]  V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [9:0]  H_VIS    = 10'(H_ACTIVE);
   localparam logic [9:0]  V_VIS    = 10'(V_ACTIVE);
   localparam logic [9:0]  HS_FIRST = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0]  HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0]  VS_FIRST = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0]  VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic [9:0]  WX_FIRST = 10'(WIN_X);
   localparam logic [9:0]  WX_LAST  = 10'(WIN_X + 2 * WIN_W - 1);
   localparam logic [9:0]  WY_FIRST = 10'(WIN_Y);
   localparam logic [9:0]  WY_LAST  = 10'(WIN_Y + 2 * WIN_H - 1);
   localparam logic [13:0] ROW_STEP = 14'(WIN_W);

   logic [9:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
   logic [6:0]  col_q, col_d;
   logic [13:0] row_base_q, row_base_d;
   logic        hphase_q, hphase_d, vphase_q, vphase_d;
   logic [15:0] rdaddr_q, rdaddr_d;
   logic        win1_q, vis1_q, hs1_q, vs1_q;
   logic        win2_q, vis2_q, hs2_q, vs2_q;
   logic [2:0]  pix_q, pix_d;
   logic        de_q, hs_q, vs_q, tick_q, tick_d;
   logic        visible, hs_raw, vs_raw, in_win;

   assign visible = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
   assign hs_raw  = !((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST));
   assign vs_raw  = !((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST));
   assign in_win  = (h_cnt_q >= WX_FIRST) && (h_cnt_q <= WX_LAST) &&
                    (v_cnt_q >= WY_FIRST) && (v_cnt_q <= WY_LAST);

   always_comb begin
      h_cnt_d    = h_cnt_q + 10'd1;
      v_cnt_d    = v_cnt_q;
      col_d      = col_q;
      row_base_d = row_base_q;
      hphase_d   = hphase_q;
      vphase_d   = vphase_q;
      if (h_cnt_q == H_LAST) begin
         h_cnt_d = '0;
         v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
      end
      // Each source pixel is shown twice per line and each source row on two lines.
      if (h_cnt_q == '0 && v_cnt_q == '0) begin
         col_d      = '0;
         row_base_d = '0;
         hphase_d   = 1'b0;
         vphase_d   = 1'b0;
      end else if (in_win) begin
         if (h_cnt_q == WX_LAST) begin
            col_d    = '0;
            hphase_d = 1'b0;
            vphase_d = !vphase_q;
            if (vphase_q)
               row_base_d = row_base_q + ROW_STEP;
         end else begin
            hphase_d = !hphase_q;
            if (hphase_q)
               col_d = col_q + 7'd1;
         end
      end
      rdaddr_d = in_win ? ({2'b00, row_base_q} + {9'd0, col_q}) : rdaddr_q;
   end

   always_comb begin
      pix_d  = (win2_q && vis2_q) ? q : 3'd0;
      tick_d = !vs2_q && vs_q;
   end

   always_ff @(posedge sysclk or negedge resetn) begin
      if (!resetn) begin
         h_cnt_q    <= '0;
         v_cnt_q    <= '0;
         col_q      <= '0;
         row_base_q <= '0;
         hphase_q   <= 1'b0;
         vphase_q   <= 1'b0;
         rdaddr_q   <= '0;
         win1_q     <= 1'b0;
         vis1_q     <= 1'b0;
         hs1_q      <= 1'b1;
         vs1_q      <= 1'b1;
         win2_q     <= 1'b0;
         vis2_q     <= 1'b0;
         hs2_q      <= 1'b1;
         vs2_q      <= 1'b1;
         pix_q      <= '0;
         de_q       <= 1'b0;
         hs_q       <= 1'b1;
         vs_q       <= 1'b1;
         tick_q     <= 1'b0;
      end else begin
         h_cnt_q    <= h_cnt_d;
         v_cnt_q    <= v_cnt_d;
         col_q      <= col_d;
         row_base_q <= row_base_d;
         hphase_q   <= hphase_d;
         vphase_q   <= vphase_d;
         rdaddr_q   <= rdaddr_d;
         win1_q     <= in_win;
         vis1_q     <= visible;
         hs1_q      <= hs_raw;
         vs1_q      <= vs_raw;
         win2_q     <= win1_q;
         vis2_q     <= vis1_q;
         hs2_q      <= hs1_q;
         vs2_q      <= vs1_q;
         pix_q      <= pix_d;
         de_q       <= vis2_q;
         hs_q       <= hs2_q;
         vs_q       <= vs2_q;
         tick_q     <= tick_d;
      end
   end

   assign rdaddr     = rdaddr_q;
   assign hs         = hs_q;
   assign vs         = vs_q;
   assign de         = de_q;
   assign vga_r      = pix_q;
   assign vga_g      = pix_q;
   assign vga_b      = pix_q;
   assign frame_tick = tick_q;

endmodule

// File: tb/tb_ram2vga.sv
// tb/tb_ram2vga.sv - directed bench for ram2vga: a default-timing instance and a reduced-timing instance
// Reduced instance: 56x37 total, 40x30 visible, hsync h 44..51, vsync v 32..33, 10x6 image at (10,8).
module tb_ram2vga;

   logic sysclk = 1'b0;
   always #5 sysclk = ~sysclk;
   logic resetn;

   logic [15:0] rdaddr_s, rdaddr_d;
   logic [2:0]  q_s, q_d, r_s, g_s, b_s, r_d, g_d, b_d;
   logic        hs_s, vs_s, de_s, ft_s, hs_d, vs_d, de_d, ft_d;

   ram2vga #(.H_ACTIVE(40), .H_FP(4), .H_SYNC(8), .H_BP(4),
             .V_ACTIVE(30), .V_FP(2), .V_SYNC(2), .V_BP(3),
             .WIN_X(10), .WIN_Y(8), .WIN_W(10), .WIN_H(6)) dut_s (
      .sysclk(sysclk), .resetn(resetn), .rdaddr(rdaddr_s), .q(q_s),
      .hs(hs_s), .vs(vs_s), .de(de_s), .vga_r(r_s), .vga_g(g_s), .vga_b(b_s),
      .frame_tick(ft_s));

   ram2vga dut_d (
      .sysclk(sysclk), .resetn(resetn), .rdaddr(rdaddr_d), .q(q_d),
      .hs(hs_d), .vs(vs_d), .de(de_d), .vga_r(r_d), .vga_g(g_d), .vga_b(b_d),
      .frame_tick(ft_d));

   always @(posedge sysclk) begin
      q_s <= rdaddr_s[2:0];
      q_d <= rdaddr_d[2:0];
   end

   int tests = 0;
   int fails = 0;
   int hl_d, first_d, hl_s, vl_s, de_cnt, ft_cnt, first_ft, addr_err, max_addr;
   int c, h, v, kf, exp_addr;
   logic prev_hs_d;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge sysclk);
      #1;
   endtask

   initial begin
      resetn = 1'b0;
      repeat (10) tick();
      check("rst_rdaddr_s", rdaddr_s, 0);
      check("rst_hs_s", hs_s, 1);
      check("rst_vs_s", vs_s, 1);
      check("rst_de_s", de_s, 0);
      check("rst_rgb_s", {r_s, g_s, b_s}, 0);
      check("rst_ft_s", ft_s, 0);
      check("rst_rdaddr_d", rdaddr_d, 0);
      check("rst_hsvs_d", {hs_d, vs_d, de_d}, 3'b110);
      check("rst_rgb_d", {r_d, g_d, b_d}, 0);

      resetn = 1'b1;
      hl_d = 0; first_d = 0; hl_s = 0; vl_s = 0; de_cnt = 0; ft_cnt = 0;
      first_ft = 0; addr_err = 0; max_addr = 0; prev_hs_d = 1'b1;
      for (int k = 1; k <= 4144; k++) begin
         tick();
         if (k <= 800) begin
            if (!hs_d) hl_d++;
            if (!hs_d && prev_hs_d && first_d == 0) first_d = k;
            prev_hs_d = hs_d;
         end
         if (!hs_s) hl_s++;
         if (!vs_s) vl_s++;
         if (de_s) de_cnt++;
         if (ft_s) begin
            ft_cnt++;
            if (first_ft == 0) first_ft = k;
         end
         c = k - 1;
         h = c % 56;
         v = (c / 56) % 37;
         if (h >= 10 && h <= 29 && v >= 8 && v <= 19) begin
            exp_addr = ((v - 8) / 2) * 10 + (h - 10) / 2;
            if (int'(rdaddr_s) != exp_addr) addr_err++;
            if (int'(rdaddr_s) > max_addr) max_addr = int'(rdaddr_s);
         end
         kf = (k - 1) % 2072 + 1;
         case (kf)
            46:   check("hs_before_fall", hs_s, 1);
            47:   check("hs_first_low", hs_s, 0);
            48:   check("de_in_hblank", de_s, 0);
            459:  check("line8_addr0", rdaddr_s, 0);
            460: begin
                  check("line8_addr0_dup", rdaddr_s, 0);
                  check("rgb_left_of_win", {r_s, g_s, b_s}, 0);
               end
            461:  check("line8_addr1", rdaddr_s, 1);
            463: begin
                  check("rgb_win_x2", {r_s, g_s, b_s}, {3{3'd1}});
                  check("de_in_win", de_s, 1);
               end
            481:  check("rgb_right_of_win", {r_s, g_s, b_s}, 0);
            515:  check("line9_addr0", rdaddr_s, 0);
            517:  check("line9_addr1", rdaddr_s, 1);
            571:  check("line10_addr10", rdaddr_s, 10);
            1094: check("last_addr", rdaddr_s, 59);
            1095: check("addr_hold", rdaddr_s, 59);
            1096: check("rgb_last_pixel", {r_s, g_s, b_s}, {3{3'd3}});
            default: ;
         endcase
      end
      check("hs_first_fall_d", first_d, 659);
      check("hs_low_line_d", hl_d, 96);
      check("hs_low_2frames", hl_s, 592);
      check("vs_low_2frames", vl_s, 224);
      check("de_high_2frames", de_cnt, 2400);
      check("frame_ticks", ft_cnt, 2);
      check("first_frame_tick", first_ft, 1795);
      check("addr_seq_errors", addr_err, 0);
      check("max_addr", max_addr, 59);

      repeat (860) tick();
      check("pre_rst_rdaddr", rdaddr_s, 34);
      check("pre_rst_rgb", {r_s, g_s, b_s}, {3{3'd1}});
      check("pre_rst_de", de_s, 1);
      resetn = 1'b0;
      #1;
      check("mid_rst_rdaddr", rdaddr_s, 0);
      check("mid_rst_rgb", {r_s, g_s, b_s}, 0);
      check("mid_rst_sync", {hs_s, vs_s, de_s, ft_s}, 4'b1100);
      repeat (3) tick();
      resetn = 1'b1;
      ft_cnt = 0;
      for (int j = 1; j <= 1795; j++) begin
         tick();
         if (j < 1795 && ft_s) ft_cnt++;
         if (j == 461) check("post_rst_line8_addr1", rdaddr_s, 1);
         if (j == 571) check("post_rst_line10_addr10", rdaddr_s, 10);
         if (j == 1795) check("post_rst_tick", ft_s, 1);
      end
      check("post_rst_no_early_tick", ft_cnt, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
